// File: rtl/mult_iter_chunked.sv
// Iterative unsigned multiplier: one CHUNKxCHUNK partial product per cycle, (WIDTH/CHUNK)^2 cycles.
// Optional macro MULT_ITER_ZERO_SKIP_EN: zero operands bypass CALC and finish in one cycle.
module mult_iter_chunked #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [IdxW-1:0]      i_q, i_d, j_q, j_d;
  logic                 busy_q, busy_d;

  logic [CHUNK-1:0]     a_dig, b_dig;
  logic [2*CHUNK-1:0]   term;
  logic [2*WIDTH-1:0]   term_ext;
  int unsigned          shamt;
  logic                 last;

  // Single partial-product unit feeding the shift-add into the accumulator.
  always_comb begin
    a_dig    = a_q[i_q*CHUNK +: CHUNK];
    b_dig    = b_q[j_q*CHUNK +: CHUNK];
    term     = {{CHUNK{1'b0}}, a_dig} * {{CHUNK{1'b0}}, b_dig};
    term_ext = '0;
    term_ext[2*CHUNK-1:0] = term;
    shamt    = CHUNK * (32'(i_q) + 32'(j_q));
    last     = (i_q == LastIdx) && (j_q == LastIdx);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = StCalc;
`ifdef MULT_ITER_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) state_d = StDone;
`endif
        end
      end
      StCalc: begin
        acc_d = acc_q + (term_ext << shamt);
        if (last) begin
          i_d     = '0;
          j_d     = '0;
          state_d = StDone;
        end else if (j_q == LastIdx) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign p         = acc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_iter_chunked.sv
// Bench for mult_iter_chunked: a 4-bit instance for the exhaustive sweep, an 8-bit one for
// latency, backpressure, reset and streaming; expected products come from plain a*b.
module tb_mult_iter_chunked;

`ifdef MULT_ITER_ZERO_SKIP_EN
  localparam bit ZeroSkip = 1'b1;
`else
  localparam bit ZeroSkip = 1'b0;
`endif

  localparam int Lat4 = (4 / 2) * (4 / 2);
  localparam int Lat8 = (8 / 2) * (8 / 2);

  logic        clk;
  logic        rst_n4, in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        rst_n8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int vectors     = 0;
  int miscompares = 0;

  mult_iter_chunked #(.WIDTH(4), .CHUNK(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .p(p4), .busy(busy4)
  );

  mult_iter_chunked #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .p(p8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One 4-bit operation with out_ready held high; ends back in IDLE.
  task automatic op4(input logic [3:0] x, input logic [3:0] y, input string tag);
    int lat;
    chk({tag, "_rdy"}, 32'(in_ready4), 32'd1);
    a4 = x; b4 = y; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), (ZeroSkip && (x == 0 || y == 0)) ? 32'd0 : 32'(Lat4));
    chk({tag, "_p"}, 32'(p4), 32'(x) * 32'(y));
    @(posedge clk); #1;
  endtask

  // One 8-bit operation with out_ready low; leaves the DUT holding its result in DONE.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input string tag);
    int lat;
    chk({tag, "_rdy"}, 32'(in_ready8), 32'd1);
    a8 = x; b8 = y; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), (ZeroSkip && (x == 0 || y == 0)) ? 32'd0 : 32'(Lat8));
    chk({tag, "_p"}, 32'(p8), 32'(x) * 32'(y));
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
  endtask

  task automatic rel8(input string tag);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk({tag, "_idle_rdy"}, 32'(in_ready8), 32'd1);
    chk({tag, "_idle_ov"}, 32'(out_valid8), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy8), 32'd0);
  endtask

  // Ten random pairs with in_valid and out_ready held high.
  task automatic stream8();
    logic [15:0] q[$];
    logic [7:0]  x, y;
    int sent = 0, got = 0, cyc = 0, last_acc = -1;
    out_ready8 = 1'b1;
    while (got < 10 && cyc < 400) begin
      if (out_valid8) begin
        if (q.size() > 0) chk("stream_p", 32'(p8), 32'(q.pop_front()));
        else chk("stream_extra", 32'(out_valid8), 32'd0);
        got++;
      end
      if (in_ready8 && sent < 10) begin
        x = 8'($urandom_range(1, 255));
        y = 8'($urandom_range(1, 255));
        a8 = x; b8 = y; in_valid8 = 1'b1;
        q.push_back(16'(x) * 16'(y));
        if (last_acc >= 0) chk("stream_gap", 32'(cyc - last_acc), 32'(Lat8 + 2));
        last_acc = cyc;
        sent++;
      end else begin
        in_valid8 = (sent < 10);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    chk("stream_count", 32'(got), 32'd10);
  endtask

  initial begin
    logic [7:0] rx, ry;
    rst_n4 = 1'b0; in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
    rst_n8 = 1'b0; in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst4_rdy", 32'(in_ready4), 32'd1);
    chk("rst4_ov", 32'(out_valid4), 32'd0);
    chk("rst4_busy", 32'(busy4), 32'd0);
    chk("rst4_p", 32'(p4), 32'd0);
    chk("rst8_rdy", 32'(in_ready8), 32'd1);
    chk("rst8_ov", 32'(out_valid8), 32'd0);
    chk("rst8_busy", 32'(busy8), 32'd0);
    chk("rst8_p", 32'(p8), 32'd0);
    rst_n4 = 1'b1; rst_n8 = 1'b1;
    @(posedge clk); #1;

    op4(4'd15, 4'd15, "w4_15x15");
    for (int i = 0; i < 256; i++) op4(4'(i >> 4), 4'(i), "w4_sweep");

    op8(8'd200, 8'd123, "w8_200x123");
    // Held result must survive backpressure while new operands are offered.
    in_valid8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_ov", 32'(out_valid8), 32'd1);
      chk("bp_p", 32'(p8), 32'd24600);
      chk("bp_rdy", 32'(in_ready8), 32'd0);
    end
    in_valid8 = 1'b0;
    rel8("bp");

    op8(8'd255, 8'd255, "w8_255x255");
    rel8("max");
    for (int k = 0; k < 4; k++) begin
      op8(8'($urandom), 8'($urandom), "w8_rand");
      rel8("rand");
    end
    op8(8'd0, 8'd77, "w8_zero");
    rel8("zero");

    // Reset landing on the 7th CALC edge.
    rx = 8'($urandom_range(1, 255)); ry = 8'($urandom_range(1, 255));
    a8 = rx; b8 = ry; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy8), 32'd1);
    rst_n8 = 1'b0;
    @(posedge clk); #1;
    rst_n8 = 1'b1;
    chk("mid_rst_rdy", 32'(in_ready8), 32'd1);
    chk("mid_rst_ov", 32'(out_valid8), 32'd0);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_p", 32'(p8), 32'd0);
    op8(8'd3, 8'd5, "w8_3x5");
    rel8("after_rst");

    stream8();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
